// File: rtl/seg_display_driver_pkg.sv
// Shared definitions for the EGO1 eight-digit display driver: segment glyphs,
// converter state encoding and display geometry.
package display_pkg;

  localparam int DIGITS_TOTAL = 8;
  localparam int DATA_W       = 32;
  localparam int BCD_W        = 40;

  // Segment bit order: bit0=a .. bit6=g, bit7=dp, active high.
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_A     = 8'h77;
  localparam logic [7:0] SEG_B     = 8'h7C;
  localparam logic [7:0] SEG_C     = 8'h39;
  localparam logic [7:0] SEG_D     = 8'h5E;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_F     = 8'h71;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_ALL   = 8'hFF;
  localparam logic [7:0] SEG_DP    = 8'h80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  function automatic logic [7:0] hex_glyph(input logic [3:0] v);
    logic [7:0] g;
    case (v)
      4'h0:    g = SEG_0;
      4'h1:    g = SEG_1;
      4'h2:    g = SEG_2;
      4'h3:    g = SEG_3;
      4'h4:    g = SEG_4;
      4'h5:    g = SEG_5;
      4'h6:    g = SEG_6;
      4'h7:    g = SEG_7;
      4'h8:    g = SEG_8;
      4'h9:    g = SEG_9;
      4'hA:    g = SEG_A;
      4'hB:    g = SEG_B;
      4'hC:    g = SEG_C;
      4'hD:    g = SEG_D;
      4'hE:    g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_display_driver_if.sv
// Bundle between the game control block (master) and the display driver (slave).
interface seg_display_driver_if;
  import display_pkg::*;

  // No valid/ready handshake: every input is a level sampled on each main_clk
  // edge, and an/seg0/seg1 are registered levels that change together on one
  // edge. conv_state mirrors the converter FSM for observation only.
  logic [DATA_W-1:0] data;
  logic [3:0]        game_d;
  logic              test;
  logic              game;
  logic [7:0]        an;
  logic [7:0]        seg0;
  logic [7:0]        seg1;
  conv_state_t       conv_state;

  modport master (
    output data, game_d, test, game,
    input  an, seg0, seg1, conv_state
  );

  modport slave (
    input  data, game_d, test, game,
    output an, seg0, seg1, conv_state
  );

endinterface

// File: rtl/seg_display_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, restarting forever,
// publishing a complete BCD result only at the end of each pass.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int BIN_W = 32,
  parameter int BCD_W = 40
) (
  input  logic             main_clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             valid,
  output conv_state_t      state_dbg
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_t      state;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] iter;

  always_comb begin
    bcd_adj = bcd_sr;
    for (int n = 0; n < BCD_W / 4; n++) begin
      if (bcd_sr[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_sr[4*n +: 4] + 4'd3;
    end
  end

  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bin_sr <= '0;
      bcd_sr <= '0;
      iter   <= '0;
      bcd    <= '0;
      valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bin_sr <= bin;
          bcd_sr <= '0;
          iter   <= CNT_W'(BIN_W);
          state  <= SHIFT;
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
          iter             <= iter - CNT_W'(1);
          if (iter == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          // Displayed value only ever moves from one finished result to the next.
          bcd   <= bcd_sr;
          valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: rtl/seg_display_driver.sv
// Eight-digit multiplexed display: digit 7 shows the player's digit, digits 6..0
// show the converted value with leading-zero blanking and an overflow dash row.
module seg_display_driver
  import display_pkg::*;
#(
  parameter int SCAN_DIV   = 1,
  parameter int NUM_DIGITS = 7,
  parameter int BIN_W      = 32
) (
  input  logic                 main_clk,
  input  logic                 rst_n,
  seg_display_driver_if.slave  bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [BCD_W-1:0]        bcd;
  logic                    valid;
  conv_state_t             conv_state;
  logic [DIV_W-1:0]        div_cnt;
  logic [2:0]              scan_idx;
  logic [DIGITS_TOTAL-1:0] lead_zero;
  logic                    overflow;
  logic [3:0]              nib;
  logic [7:0]              glyph;

  bin2bcd_seq #(
    .BIN_W (BIN_W),
    .BCD_W (BCD_W)
  ) u_bin2bcd (
    .main_clk  (main_clk),
    .rst_n     (rst_n),
    .bin       (bus.data),
    .bcd       (bcd),
    .valid     (valid),
    .state_dbg (conv_state)
  );

  assign bus.conv_state = conv_state;

  // Anything in the nibbles above the seven shown digits means it will not fit.
  assign overflow = |bcd[BCD_W-1:4*NUM_DIGITS];

  // lead_zero[i]: value digit i and every value digit above it are zero.
  always_comb begin
    lead_zero = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lead_zero[i] = ((bcd[4*NUM_DIGITS-1:0] >> (4 * i)) == '0);
    end
  end

  assign nib = bcd[{scan_idx, 2'b00} +: 4];

  always_comb begin
    glyph = SEG_BLANK;
    if (bus.test) begin
      glyph = SEG_ALL;
    end else if (scan_idx == 3'(DIGITS_TOTAL - 1)) begin
      glyph = bus.game ? hex_glyph(bus.game_d) : (SEG_E | SEG_DP);
    end else if (!valid) begin
      glyph = SEG_BLANK;
    end else if (overflow) begin
      glyph = SEG_DASH;
    end else if ((scan_idx != 3'd0) && lead_zero[scan_idx]) begin
      glyph = SEG_BLANK;
    end else begin
      glyph = hex_glyph(nib);
    end
  end

  // an and both buses come from the same scan_idx on the same edge, so a digit
  // enable never meets the previous digit's segments.
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      scan_idx <= '0;
      bus.an   <= 8'h00;
      bus.seg0 <= 8'h00;
      bus.seg1 <= 8'h00;
    end else begin
      bus.an   <= 8'h01 << scan_idx;
      bus.seg0 <= scan_idx[2] ? SEG_BLANK : glyph;
      bus.seg1 <= scan_idx[2] ? glyph : SEG_BLANK;
      if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
        div_cnt  <= '0;
        scan_idx <= scan_idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver: frame vectors from a table plus
// hand-written reset, data-change and lamp-test sequences.
module tb_seg_display_driver;
  import display_pkg::*;

  // ---------------- clock / reset ----------------
  logic main_clk = 1'b0;
  logic rst_n    = 1'b0;

  always #5 main_clk = ~main_clk;

  seg_display_driver_if bus();

  seg_display_driver #(
    .SCAN_DIV   (1),
    .NUM_DIGITS (7),
    .BIN_W      (32)
  ) dut (
    .main_clk (main_clk),
    .rst_n    (rst_n),
    .bus      (bus.slave)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_seg[8];

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int onehot_pos(input logic [7:0] v);
    if (!$onehot(v)) return -1;
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] active_seg(input int pos);
    return (pos < 4) ? bus.seg0 : bus.seg1;
  endfunction

  function automatic logic [7:0] idle_seg(input int pos);
    return (pos < 4) ? bus.seg1 : bus.seg0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [31:0] d, input logic [3:0] gd, input logic t, input logic g);
    @(negedge main_clk);
    bus.data   = d;
    bus.game_d = gd;
    bus.test   = t;
    bus.game   = g;
  endtask

  // Samples eight slots; records each digit's glyph from the bus that owns it.
  task automatic capture_frame(input string tag);
    int pos;
    for (int d = 0; d < 8; d++) got_seg[d] = 8'hxx;
    for (int k = 0; k < 8; k++) begin
      @(posedge main_clk); #1;
      pos = onehot_pos(bus.an);
      n_checks++;
      if (pos < 0) begin
        n_fail++;
        $display("FAIL %s_an_onehot: got %02h expected one-hot", tag, bus.an);
      end else begin
        check8($sformatf("%s_idle_bus_d%0d", tag, pos), idle_seg(pos), 8'h00);
        got_seg[pos] = active_seg(pos);
      end
    end
  endtask

  // Asserts reset between edges, then follows the scan from its first slot;
  // value digits stay blank until the first conversion completes.
  task automatic reset_and_scan(input logic [7:0] d7_exp, input string tag);
    logic [7:0] an_exp;
    @(negedge main_clk);
    rst_n = 1'b0;
    #1;
    check8({tag, "_rst_an"},   bus.an,   8'h00);
    check8({tag, "_rst_seg0"}, bus.seg0, 8'h00);
    check8({tag, "_rst_seg1"}, bus.seg1, 8'h00);
    check8({tag, "_rst_state"}, 8'(bus.conv_state), 8'(IDLE));
    repeat (2) @(negedge main_clk);
    check8({tag, "_rst_hold_an"}, bus.an, 8'h00);
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(posedge main_clk); #1;
      an_exp = 8'h01 << (k % 8);
      check8($sformatf("%s_scan_an_%0d", tag, k), bus.an, an_exp);
      check8($sformatf("%s_scan_seg0_%0d", tag, k), bus.seg0, 8'h00);
      check8($sformatf("%s_scan_seg1_%0d", tag, k), bus.seg1,
             ((k % 8) == 7) ? d7_exp : 8'h00);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0]     data;
    logic [3:0]      game_d;
    logic            test;
    logic            game;
    logic [7:0][7:0] exp;   // exp[7] is digit 7 (leftmost)
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  pos;
    int  seen_at;
    bit  seen_new;
    bit  seen_old;

    vecs[0] = '{32'd12345,      4'h7, 1'b0, 1'b1,
                {8'h07, 8'h00, 8'h00, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D}};
    vecs[1] = '{32'd0,          4'hA, 1'b0, 1'b1,
                {8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F}};
    vecs[2] = '{32'd9999999,    4'hB, 1'b0, 1'b1,
                {8'h7C, 8'h6F, 8'h6F, 8'h6F, 8'h6F, 8'h6F, 8'h6F, 8'h6F}};
    vecs[3] = '{32'd10000000,   4'h3, 1'b0, 1'b0,
                {8'hF9, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40}};
    vecs[4] = '{32'd12345,      4'h7, 1'b1, 1'b1,
                {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[5] = '{32'd100,        4'hF, 1'b0, 1'b1,
                {8'h71, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06, 8'h3F, 8'h3F}};
    vecs[6] = '{32'hFFFF_FFFF,  4'h0, 1'b0, 1'b1,
                {8'h3F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40}};
    vecs[7] = '{32'd1000000,    4'h2, 1'b0, 1'b1,
                {8'h5B, 8'h06, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F}};

    bus.data   = 32'd5;
    bus.game_d = 4'h7;
    bus.test   = 1'b0;
    bus.game   = 1'b1;

    // Power-on reset and scan order.
    reset_and_scan(8'h07, "por");

    // Data 5 -> 42 partway through the second conversion after reset.
    repeat (12) @(posedge main_clk);
    @(negedge main_clk);
    bus.data = 32'd42;
    seen_new = 1'b0;
    seen_old = 1'b0;
    seen_at  = -1;
    for (int k = 0; k < 80; k++) begin
      @(posedge main_clk); #1;
      pos = onehot_pos(bus.an);
      if (pos == 0) begin
        if (!seen_new && bus.seg0 == 8'h5B) begin
          seen_new = 1'b1;
          seen_at  = k;
        end
        if (seen_new) check8("chg_d0_new", bus.seg0, 8'h5B);
        else begin
          check8("chg_d0_old", bus.seg0, 8'h6D);
          seen_old = 1'b1;
        end
      end else if (pos == 1) begin
        check8("chg_d1", bus.seg0, seen_new ? 8'h66 : 8'h00);
      end else if (pos >= 2 && pos <= 6) begin
        check8($sformatf("chg_d%0d", pos), active_seg(pos), 8'h00);
      end
    end
    check8("chg_seen_old", 8'(seen_old), 8'h01);
    check8("chg_seen_new", 8'(seen_new), 8'h01);
    n_checks++;
    if (seen_at < 0 || seen_at > 68) begin
      n_fail++;
      $display("FAIL chg_latency: got %0d cycles required <= 68", seen_at);
    end

    // Table of full-frame images.
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].data, vecs[i].game_d, vecs[i].test, vecs[i].game);
      repeat (70) @(posedge main_clk);
      for (int d = 0; d < 8; d++) exp_q.push_back(vecs[i].exp[d]);
      capture_frame($sformatf("v%0d", i));
      for (int d = 0; d < 8; d++) begin
        check8($sformatf("v%0d_d%0d", i, d), got_seg[d], exp_q.pop_front());
      end
    end

    // Lamp test on, then off: the very next slot returns to the normal image.
    @(negedge main_clk);
    bus.test = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge main_clk); #1;
      pos = onehot_pos(bus.an);
      if (pos >= 0) check8($sformatf("lamp_d%0d", pos), active_seg(pos), 8'hFF);
      else check8("lamp_an", bus.an, 8'h01);
    end
    @(negedge main_clk);
    bus.test = 1'b0;
    @(posedge main_clk); #1;
    pos = onehot_pos(bus.an);
    if (pos >= 0) check8($sformatf("lamp_off_d%0d", pos), active_seg(pos), vecs[7].exp[pos]);
    else check8("lamp_off_an", bus.an, 8'h01);

    // Reset in the middle of SHIFT clears the displayed value.
    pos = 0;
    while (pos < 100 && bus.conv_state != SHIFT) begin
      @(posedge main_clk); #1;
      pos++;
    end
    check8("mid_wait_shift", 8'(bus.conv_state), 8'(SHIFT));
    repeat (5) @(posedge main_clk);
    reset_and_scan(8'h5B, "mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
